// File: rtl/nrisc_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding,
// requester identities and the legal memory-latency bounds.
package nrisc_pkg;

   // Memory read latency limits in cycles; the counter width covers MAX-1.
   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 3;
   localparam int LAT_W       = 2;

   // Arbiter FSM: one access in flight at a time.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_e;

   // Requester identity; REQ_IF is the reset value of the last-grant pointer,
   // so data wins the first conflict when fair arbitration is built in.
   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_D  = 1'b1
   } req_id_e;

endpackage

// File: rtl/lat_counter.sv
// Read-latency down-counter: loads LOAD when a read is issued, decrements
// while the arbiter waits, and flags zero on the capture cycle.
module lat_counter
   import nrisc_pkg::*;
#(
   parameter int LOAD = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic dec,
   output logic zero
);

   logic [LAT_W-1:0] cnt;

   // Load on issue, count down toward zero while waiting; never wraps.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LAT_W'(LOAD);
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - LAT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch port and the
// data port. One access is outstanding at a time: IDLE -> ISSUE -> (WAIT) ->
// DONE -> IDLE. Data requests win by fixed priority; building with the macro
// FAIR_ARB_EN replaces this with alternation driven by a last-grant pointer.
//
// Handshake: a requester raises its req (if_req / d_rd / d_wr) and holds it
// with stable address/data until its gnt pulses (the ISSUE cycle); gnt means
// the access is on the memory bus that cycle. The matching valid pulses for
// one cycle when the access completes (rdata is valid from that cycle until
// the next capture). A request dropped before its gnt is simply forgotten.
module mem_port_arbiter
   import nrisc_pkg::*;
#(
   parameter int MEM_LAT = 1  // legal range MEM_LAT_MIN..MEM_LAT_MAX
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       if_req,
   input  logic [7:0] if_addr,
   output logic       if_gnt,
   output logic       if_valid,
   output logic [7:0] if_rdata,
   input  logic       d_rd,
   input  logic       d_wr,
   input  logic [7:0] d_addr,
   input  logic [7:0] d_wdata,
   output logic       d_gnt,
   output logic       d_valid,
   output logic [7:0] d_rdata,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_r,
   output logic       mem_w,
   input  logic [7:0] mem_rdata,
   output logic       stall,
   output logic       err,
   output arb_state_e dbg_state
);

   arb_state_e state, state_nx;
   req_id_e    win_id;
   req_id_e    winner_q;
   logic       d_req, any_req, grant, win_rd, cnt_zero;
   logic [7:0] addr_q, wdata_q, if_rdata_q, d_rdata_q;
   logic       err_q;

   assign d_req   = d_rd | d_wr;
   assign any_req = if_req | d_req;

`ifdef FAIR_ARB_EN
   req_id_e last_q;

   // On a conflict, grant the requester that did not win last time.
   always_comb begin
      win_id = REQ_IF;
      if (d_req && if_req) begin
         win_id = (last_q == REQ_D) ? REQ_IF : REQ_D;
      end else if (d_req) begin
         win_id = REQ_D;
      end
   end

   // Remember who was granted most recently.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q <= REQ_IF;
      end else if (grant) begin
         last_q <= win_id;
      end
   end
`else
   // Fixed priority: any data request beats a fetch.
   always_comb begin
      win_id = d_req ? REQ_D : REQ_IF;
   end
`endif

   // Fetches are always reads; a data request with both strobes is a read.
   assign win_rd = (win_id == REQ_IF) | d_rd;
   assign grant  = (state == ISSUE) & any_req;

   lat_counter #(
      .LOAD (MEM_LAT - 1)
   ) u_lat (
      .clk   (clk),
      .reset (reset),
      .load  (grant & win_rd),
      .dec   (state == WAIT),
      .zero  (cnt_zero)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state plus all combinational outputs.
   always_comb begin
      state_nx  = state;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      mem_r     = 1'b0;
      mem_w     = 1'b0;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      if_valid  = 1'b0;
      d_valid   = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) state_nx = ISSUE;
         end
         ISSUE: begin
            if (!any_req) begin
               state_nx = IDLE;
            end else begin
               if_gnt   = (win_id == REQ_IF);
               d_gnt    = (win_id == REQ_D);
               mem_r    = win_rd;
               mem_w    = ~win_rd;
               mem_addr = (win_id == REQ_D) ? d_addr : if_addr;
               if (win_id == REQ_D) mem_wdata = d_wdata;
               state_nx = win_rd ? WAIT : DONE;
            end
         end
         WAIT: begin
            if (cnt_zero) state_nx = DONE;
         end
         DONE: begin
            if_valid = (winner_q == REQ_IF);
            d_valid  = (winner_q == REQ_D);
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Latch the winner and the bus values so mem_* hold while idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         winner_q <= REQ_IF;
         addr_q   <= 8'h00;
         wdata_q  <= 8'h00;
      end else if (grant) begin
         winner_q <= win_id;
         addr_q   <= mem_addr;
         wdata_q  <= mem_wdata;
      end
   end

   // Capture read data on the last wait cycle into the winner's register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if_rdata_q <= 8'h00;
         d_rdata_q  <= 8'h00;
      end else if ((state == WAIT) && cnt_zero) begin
         if (winner_q == REQ_IF) begin
            if_rdata_q <= mem_rdata;
         end else begin
            d_rdata_q <= mem_rdata;
         end
      end
   end

   // Sticky error: a data request arrived with both read and write strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (grant && (win_id == REQ_D) && d_rd && d_wr) begin
         err_q <= 1'b1;
      end
   end

   // Hold the processor while a request waits or a read is in flight;
   // forced low while reset is asserted.
   assign stall     = reset & ((state == WAIT) | any_req);
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign err       = err_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), a
// small memory model per instance, directed accesses, and a scoreboard that
// pairs every valid pulse with a pre-computed expectation.
module tb_mem_port_arbiter;
  import nrisc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT signals (index 0: MEM_LAT=1, index 1: MEM_LAT=3) ----
  logic       if_req    [2];
  logic [7:0] if_addr   [2];
  logic       d_rd      [2];
  logic       d_wr      [2];
  logic [7:0] d_addr    [2];
  logic [7:0] d_wdata   [2];
  logic       if_gnt    [2];
  logic       if_valid  [2];
  logic [7:0] if_rdata  [2];
  logic       d_gnt     [2];
  logic       d_valid   [2];
  logic [7:0] d_rdata   [2];
  logic [7:0] mem_addr  [2];
  logic [7:0] mem_wdata [2];
  logic       mem_r     [2];
  logic       mem_w     [2];
  logic [7:0] mem_rdata [2];
  logic       stall     [2];
  logic       err       [2];
  arb_state_e dbg_state [2];

  mem_port_arbiter #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(rst_n),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_valid(if_valid[0]), .if_rdata(if_rdata[0]),
    .d_rd(d_rd[0]), .d_wr(d_wr[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_gnt(d_gnt[0]), .d_valid(d_valid[0]), .d_rdata(d_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_r(mem_r[0]),
    .mem_w(mem_w[0]), .mem_rdata(mem_rdata[0]), .stall(stall[0]),
    .err(err[0]), .dbg_state(dbg_state[0])
  );

  mem_port_arbiter #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(rst_n),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_valid(if_valid[1]), .if_rdata(if_rdata[1]),
    .d_rd(d_rd[1]), .d_wr(d_wr[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_gnt(d_gnt[1]), .d_valid(d_valid[1]), .d_rdata(d_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_r(mem_r[1]),
    .mem_w(mem_w[1]), .mem_rdata(mem_rdata[1]), .stall(stall[1]),
    .err(err[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- memory model ----------------
  // Read data is presented only in the cycle exactly MEM_LAT after mem_r;
  // every other cycle shows 8'hEE so a mistimed capture is visible.
  logic [7:0] mem    [256];
  logic [7:0] pipe_d [2][3];
  logic       pipe_v [2][3];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hFF;
    mem[8'h05] <= 8'hA3;
    mem[8'h06] <= 8'h3C;
    mem[8'h20] <= 8'hC4;
    mem[8'h30] <= 8'h5D;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 3; j++) begin
        pipe_v[k][j] <= 1'b0;
        pipe_d[k][j] <= 8'h00;
      end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_w[k]) mem[mem_addr[k]] <= mem_wdata[k];
      pipe_d[k][0] <= mem[mem_addr[k]];
      pipe_v[k][0] <= mem_r[k];
      pipe_d[k][1] <= pipe_d[k][0];
      pipe_v[k][1] <= pipe_v[k][0];
      pipe_d[k][2] <= pipe_d[k][1];
      pipe_v[k][2] <= pipe_v[k][1];
    end
  end

  assign mem_rdata[0] = pipe_v[0][0] ? pipe_d[0][0] : 8'hEE;
  assign mem_rdata[1] = pipe_v[1][2] ? pipe_d[1][2] : 8'hEE;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic       inst;
    logic       is_d;
    logic       chk;
    logic [7:0] data;
    logic [3:0] lat;
    logic       st;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   gnt_cyc[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_v(input int k, input bit is_d, input bit chk,
                          input logic [7:0] data, input int lat, input bit st);
    exp_t e;
    e.inst = 1'(k);
    e.is_d = is_d;
    e.chk  = chk;
    e.data = data;
    e.lat  = 4'(lat);
    e.st   = st;
    exp_q.push_back(e);
  endtask

  // Monitor: pop one expectation per valid pulse.
  initial begin
    exp_t e;
    gnt_cyc[0] = 0;
    gnt_cyc[1] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (if_gnt[k] || d_gnt[k]) gnt_cyc[k] = cyc;
        if (if_valid[k] || d_valid[k]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'(k), 32'hFFFF);
          end else begin
            e = exp_q.pop_front();
            check("valid_port", {29'd0, 1'(k), d_valid[k], if_valid[k]},
                  {29'd0, e.inst, e.is_d, ~e.is_d});
            if (e.chk)
              check("rdata", 32'(e.is_d ? d_rdata[k] : if_rdata[k]), 32'(e.data));
            check("gnt_to_valid", 32'(cyc - gnt_cyc[k]), 32'(e.lat));
            check("stall_at_valid", 32'(stall[k]), 32'(e.st));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // kind: 0 fetch, 1 data read, 2 data write, 3 data read+write
  task automatic set_req(input int k, input int kind, input logic v);
    if (kind == 0) if_req[k] = v;
    else begin
      d_rd[k] = v && (kind != 2);
      d_wr[k] = v && (kind >= 2);
    end
  endtask

  task automatic issue(input int k, input int kind, input logic [7:0] a,
                       input logic [7:0] wd, output int n);
    logic got;
    @(posedge clk); #1;
    if (kind == 0) if_addr[k] = a;
    else begin
      d_addr[k]  = a;
      d_wdata[k] = wd;
    end
    set_req(k, kind, 1'b1);
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      got = (kind == 0) ? if_gnt[k] : d_gnt[k];
    end
    if (!got) begin
      check("gnt_timeout", 32'(n), 32'd0);
    end else begin
      check("gnt_mem_addr", 32'(mem_addr[k]), 32'(a));
      check("gnt_mem_rw", {30'd0, mem_r[k], mem_w[k]}, (kind == 2) ? 32'd1 : 32'd2);
      check("gnt_stall", 32'(stall[k]), 32'd1);
      if (kind == 2) check("gnt_mem_wdata", 32'(mem_wdata[k]), 32'(wd));
    end
    @(posedge clk); #1;
    set_req(k, kind, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input int k);
    check("rst_ctrl", {24'd0, if_gnt[k], d_gnt[k], if_valid[k], d_valid[k],
                       mem_r[k], mem_w[k], stall[k], err[k]}, 32'd0);
    check("rst_data", {if_rdata[k], d_rdata[k], mem_addr[k], mem_wdata[k]}, 32'd0);
    check("rst_state", 32'(dbg_state[k]), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   n, n2, g;
    logic got;
    logic exp_id [4];

    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0; if_addr[k] = 0; d_rd[k] = 0; d_wr[k] = 0;
      d_addr[k] = 0; d_wdata[k] = 0;
    end

    // Reset with a fetch request held: nothing may be granted or stalled.
    if_req[0] = 1'b1;
    if_addr[0] = 8'h05;
    repeat (2) @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    if_req[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single fetch, MEM_LAT=1: gnt in cycle 1, valid two cycles later.
    expect_v(0, 1'b0, 1'b1, 8'hA3, 2, 1'b0);
    issue(0, 0, 8'h05, 8'h00, n);
    check("if_gnt_cycle", 32'(n), 32'd2);
    drain();

    // Fetch and store together: store first, fetch on the next issue.
    expect_v(0, 1'b1, 1'b0, 8'h00, 1, 1'b1);
    expect_v(0, 1'b0, 1'b1, 8'h3C, 2, 1'b0);
    fork
      issue(0, 2, 8'h10, 8'h7E, n);
      issue(0, 0, 8'h06, 8'h00, n2);
    join
    drain();
    check("d_rdata_after_write", 32'(d_rdata[0]), 32'h00);
    check("idle_mem_addr_hold", 32'(mem_addr[0]), 32'h06);
    check("idle_mem_wdata_hold", 32'(mem_wdata[0]), 32'h7E);
    check("fetch_after_store", 32'(n2 > n), 32'd1);

    // Read and write strobes together: performed as a read, err sticks.
    expect_v(0, 1'b1, 1'b1, 8'h5D, 2, 1'b0);
    issue(0, 3, 8'h30, 8'h99, n);
    drain();
    check("err_set", 32'(err[0]), 32'd1);
    repeat (5) @(negedge clk);
    check("err_sticky", 32'(err[0]), 32'd1);

    // Reset clears err and the arbitration history.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("err_cleared", 32'(err[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Both requesters continuously pending for four grants.
`ifdef FAIR_ARB_EN
    exp_id[0] = 1'b1; exp_id[1] = 1'b0; exp_id[2] = 1'b1; exp_id[3] = 1'b0;
    expect_v(0, 1'b1, 1'b1, 8'h7E, 2, 1'b1);
    expect_v(0, 1'b0, 1'b1, 8'hA3, 2, 1'b1);
    expect_v(0, 1'b1, 1'b1, 8'h7E, 2, 1'b1);
    expect_v(0, 1'b0, 1'b1, 8'hA3, 2, 1'b0);
`else
    exp_id[0] = 1'b1; exp_id[1] = 1'b1; exp_id[2] = 1'b1; exp_id[3] = 1'b1;
    expect_v(0, 1'b1, 1'b1, 8'h7E, 2, 1'b1);
    expect_v(0, 1'b1, 1'b1, 8'h7E, 2, 1'b1);
    expect_v(0, 1'b1, 1'b1, 8'h7E, 2, 1'b1);
    expect_v(0, 1'b1, 1'b1, 8'h7E, 2, 1'b0);
`endif
    @(posedge clk); #1;
    d_addr[0]  = 8'h10;
    d_rd[0]    = 1'b1;
    if_addr[0] = 8'h05;
    if_req[0]  = 1'b1;
    for (g = 0; g < 4; g++) begin
      n   = 0;
      got = 1'b0;
      while (!got && n < 40) begin
        @(negedge clk);
        n++;
        got = if_gnt[0] || d_gnt[0];
      end
      if (!got) check("conflict_gnt_timeout", 32'(g), 32'hFFFF);
      else      check("conflict_order", 32'(d_gnt[0]), 32'(exp_id[g]));
    end
    @(posedge clk); #1;
    d_rd[0]   = 1'b0;
    if_req[0] = 1'b0;
    drain();

    // MEM_LAT=3 data read: valid four cycles after gnt, data from cycle 3.
    expect_v(1, 1'b1, 1'b1, 8'hC4, 4, 1'b0);
    issue(1, 1, 8'h20, 8'h00, n);
    drain();

    // Reset during WAIT aborts silently; the next access completes normally.
    issue(1, 1, 8'h20, 8'h00, n);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs(1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    expect_v(1, 1'b0, 1'b1, 8'hA3, 4, 1'b0);
    issue(1, 0, 8'h05, 8'h00, n);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1: memory read latency in cycles, legal range 1..3.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
REQ-004 SHALL have port if_req, input, 1 bit: instruction fetch request, held until if_gnt.
REQ-005 SHALL have port if_addr, input, 8 bits: fetch address (PC).
REQ-006 SHALL have port if_gnt, output, 1 bit: one-cycle pulse when the fetch is issued to memory.
REQ-007 SHALL have port if_valid, output, 1 bit: one-cycle pulse when if_rdata is valid.
REQ-008 SHALL have port if_rdata, output, 8 bits: fetched instruction.
REQ-009 SHALL have ports d_rd and d_wr, inputs, 1 bit each: data read/write request, held until d_gnt.
REQ-010 SHALL have ports d_addr and d_wdata, inputs, 8 bits each: data address and store data.
REQ-011 SHALL have ports d_gnt and d_valid, outputs, 1 bit each: data issue pulse and completion pulse.
REQ-012 SHALL have port d_rdata, output, 8 bits: load data.
REQ-013 SHALL have ports mem_addr and mem_wdata, outputs, 8 bits each: shared single-port memory address and write data.
REQ-014 SHALL have ports mem_r and mem_w, outputs, 1 bit each: memory read/write strobes.
REQ-015 SHALL have port mem_rdata, input, 8 bits: memory read data, valid MEM_LAT cycles after the mem_r cycle.
REQ-016 SHALL have port stall, output, 1 bit: processor hold request.
REQ-017 SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE, with at most one access outstanding at any time.
REQ-019 IDLE with any request SHALL go to ISSUE the next cycle; with no request it SHALL stay in IDLE.
REQ-020 In ISSUE, the arbiter SHALL drive mem_* from the winner's address and data, pulse the winner's gnt, and latch the winner's identity.
REQ-021 From ISSUE, a read SHALL go to WAIT and a write SHALL go to DONE.
REQ-022 WAIT SHALL count MEM_LAT-1 further cycles, capture mem_rdata into the winner's rdata register, then go to DONE.
REQ-023 DONE SHALL pulse the winner's valid for one cycle, hold the rdata register stable until the next capture, then return to IDLE.
REQ-024 Latency from gnt to valid SHALL be MEM_LAT+1 cycles for a read and 1 cycle for a write.
REQ-025 Arbitration (default) SHALL be fixed priority: a data request wins over if_req in the same cycle.
REQ-026 Simultaneous d_rd and d_wr SHALL be executed as a read and SHALL set err.
REQ-027 err SHALL clear only on reset.
REQ-028 mem_r and mem_w SHALL be asserted only in the ISSUE state.
REQ-029 mem_addr and mem_wdata SHALL hold their last value when idle.
REQ-030 stall SHALL be high whenever a request (if_req, d_rd or d_wr) is asserted and its valid has not yet pulsed.
REQ-031 stall SHALL be combinational from the requests and the FSM state, and SHALL be low in the cycle the winner's valid pulses if no other request is pending.
REQ-032 A request dropped before its gnt SHALL be ignored, with no memory access.

Reset
REQ-033 While reset is low, the FSM SHALL be in IDLE, and all gnt, valid, mem_r, mem_w, stall and err outputs SHALL be 0.
REQ-034 While reset is low, if_rdata, d_rdata, mem_addr and mem_wdata SHALL be 8'h00, and the latency counter and last-grant pointer SHALL be 0.
REQ-035 Reset asserted mid-access SHALL abort the access with no valid pulse; after deassertion, the first access SHALL start from IDLE.

Configuration
REQ-036 With macro FAIR_ARB_EN defined, the arbiter SHALL alternate between requesters when both are pending, using a last-grant pointer (data wins at the first conflict after reset).
REQ-037 Without FAIR_ARB_EN, the arbiter SHALL use the fixed data priority of REQ-025, and the pointer SHALL not exist.

Structure
REQ-038 The FSM state encoding, the requester-ID enum (REQ_IF and REQ_D) and the MEM_LAT bounds SHALL live in shared package nrisc_pkg.
REQ-039 The latency counter SHALL be one sub-module, lat_counter (load MEM_LAT-1, decrement, zero flag).

Verification
REQ-040 MEM_LAT=1, if_req with if_addr=8'h05 and mem_rdata=8'hA3 -> if_gnt at cycle 1, if_valid at cycle 3, if_rdata=8'hA3, stall low after the valid.
REQ-041 if_req and d_wr (addr 8'h10, wdata 8'h7E) in the same cycle -> d_gnt first with mem_w=1, mem_addr=8'h10 and mem_wdata=8'h7E; d_valid 1 cycle later; if_gnt on the next ISSUE.
REQ-042 MEM_LAT=3, d_rd to 8'h20 -> d_valid exactly 4 cycles after d_gnt, and mem_rdata is sampled at the MEM_LAT cycle.
REQ-043 d_rd=d_wr=1 -> read performed, mem_w never asserted, err=1 held until reset.
REQ-044 Reset pulsed low during WAIT -> no valid pulse, all outputs 0; the next request completes normally.
REQ-045 FAIR_ARB_EN defined, both requesters continuously pending -> grants alternate D, IF, D, IF; without the macro, IF is never granted.
